// File: rtl/board_pkg.sv
// Board-wide constants shared by the switch conditioning path and its consumers.
package board_pkg;

    localparam int SW_WIDTH    = 10;
    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 10;

    // Cycles of stable input required before a switch change is accepted.
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, debounced output and change pulse.
module sw_debounce_bit
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_db,
    output logic sw_changed_mask,
    output logic mask_next
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          fire;

    // The top ORs mask_next across bits so its strobe lands with the mask.
    always_comb begin
        differ    = (s2 != sw_db);
        fire      = differ && (cnt == CNT_LAST);
        mask_next = fire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1              <= 1'b0;
            s2              <= 1'b0;
            cnt             <= '0;
            sw_db           <= 1'b0;
            sw_changed_mask <= 1'b0;
        end else begin
            s1              <= sw_raw;
            s2              <= s1;
            sw_changed_mask <= fire;
            if (!differ) begin
                cnt <= '0;
            end else if (fire) begin
                sw_db <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Switch-pin conditioning: per-bit synchronise and debounce, plus a shared change strobe.
module sw_debounce
    import board_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic             sw_changed,
    output logic [WIDTH-1:0] sw_changed_mask
);

    logic [WIDTH-1:0] mask_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk            (clk),
            .rst            (rst),
            .sw_raw         (sw_raw[i]),
            .sw_db          (sw_db[i]),
            .sw_changed_mask(sw_changed_mask[i]),
            .mask_next      (mask_next[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= |mask_next;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with WIDTH=10, DEBOUNCE_CYCLES=4.
module tb_sw_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sw_raw = 10'h3FF;
    logic [9:0] sw_db;
    logic       sw_changed;
    logic [9:0] sw_changed_mask;

    typedef struct {
        int         edge_no;
        logic [9:0] db;
        logic [9:0] mask;
    } exp_t;

    exp_t       sb[$];
    exp_t       ex;
    logic [9:0] cur_db;
    int         checks   = 0;
    int         failures = 0;

    sw_debounce #(.WIDTH(10), .DEBOUNCE_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .sw_raw         (sw_raw),
        .sw_db          (sw_db),
        .sw_changed     (sw_changed),
        .sw_changed_mask(sw_changed_mask)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        sw_raw = 10'h000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        cur_db = 10'h000;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        sw_raw = 10'h3FF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (sw_db !== 10'h000 || sw_changed !== 1'b0 || sw_changed_mask !== 10'h000) begin
                failures++;
                $display("FAIL reset cyc=%0d db=%h changed=%b mask=%h required db=000 changed=0 mask=000",
                         c, sw_db, sw_changed, sw_changed_mask);
            end
        end
        sw_raw = 10'h000;
        rst    = 1'b0;
        cur_db = 10'h000;
        sb.delete();
    endtask

    task automatic test_clean_edge();
        sb.push_back('{edge_no: 5, db: 10'h001, mask: 10'h001});
        for (int e = 0; e < 10; e++) begin
            sw_raw = 10'h001;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (sw_changed !== 1'b0 || sw_changed_mask !== 10'h000) begin
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL clean unexpected pulse edge=%0d changed=%b mask=%h", e, sw_changed, sw_changed_mask);
                end else begin
                    ex = sb.pop_front();
                    if (e != ex.edge_no || sw_changed !== 1'b1 || sw_db !== ex.db || sw_changed_mask !== ex.mask) begin
                        failures++;
                        $display("FAIL clean pulse edge=%0d db=%h mask=%h changed=%b required edge=%0d db=%h mask=%h changed=1",
                                 e, sw_db, sw_changed_mask, sw_changed, ex.edge_no, ex.db, ex.mask);
                    end
                    cur_db = ex.db;
                end
            end else if (sw_db !== cur_db) begin
                failures++;
                $display("FAIL clean db edge=%0d got=%h required=%h", e, sw_db, cur_db);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL clean missed pulse got=none required=%0d pending", sb.size());
        end
    endtask

    task automatic test_bounce();
        logic b;
        sb.push_back('{edge_no: 17, db: 10'h009, mask: 10'h008});
        for (int e = 0; e < 22; e++) begin
            b      = (e < 12) ? (((e / 3) % 2) == 0) : 1'b1;
            sw_raw = 10'h001 | (b ? 10'h008 : 10'h000);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (sw_changed !== 1'b0 || sw_changed_mask !== 10'h000) begin
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL bounce unexpected pulse edge=%0d changed=%b mask=%h", e, sw_changed, sw_changed_mask);
                end else begin
                    ex = sb.pop_front();
                    if (e != ex.edge_no || sw_changed !== 1'b1 || sw_db !== ex.db || sw_changed_mask !== ex.mask) begin
                        failures++;
                        $display("FAIL bounce pulse edge=%0d db=%h mask=%h changed=%b required edge=%0d db=%h mask=%h changed=1",
                                 e, sw_db, sw_changed_mask, sw_changed, ex.edge_no, ex.db, ex.mask);
                    end
                    cur_db = ex.db;
                end
            end else if (sw_db !== cur_db) begin
                failures++;
                $display("FAIL bounce db edge=%0d got=%h required=%h", e, sw_db, cur_db);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL bounce missed pulse got=none required=%0d pending", sb.size());
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        sb.push_back('{edge_no: 5, db: 10'h300, mask: 10'h300});
        for (int e = 0; e < 9; e++) begin
            sw_raw = 10'h300;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (sw_changed !== 1'b0 || sw_changed_mask !== 10'h000) begin
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL simul unexpected pulse edge=%0d changed=%b mask=%h", e, sw_changed, sw_changed_mask);
                end else begin
                    ex = sb.pop_front();
                    if (e != ex.edge_no || sw_changed !== 1'b1 || sw_db !== ex.db || sw_changed_mask !== ex.mask) begin
                        failures++;
                        $display("FAIL simul pulse edge=%0d db=%h mask=%h changed=%b required edge=%0d db=%h mask=%h changed=1",
                                 e, sw_db, sw_changed_mask, sw_changed, ex.edge_no, ex.db, ex.mask);
                    end
                    cur_db = ex.db;
                end
            end else if (sw_db !== cur_db) begin
                failures++;
                $display("FAIL simul db edge=%0d got=%h required=%h", e, sw_db, cur_db);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL simul missed pulse got=none required=%0d pending", sb.size());
        end
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        for (int e = 0; e < 4; e++) begin
            sw_raw = 10'h010;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (sw_changed !== 1'b0 || sw_changed_mask !== 10'h000 || sw_db !== 10'h000) begin
                failures++;
                $display("FAIL midrst early edge=%0d db=%h changed=%b mask=%h required db=000 changed=0 mask=000",
                         e, sw_db, sw_changed, sw_changed_mask);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sw_changed !== 1'b0 || sw_changed_mask !== 10'h000 || sw_db !== 10'h000) begin
            failures++;
            $display("FAIL midrst assert db=%h changed=%b mask=%h required db=000 changed=0 mask=000",
                     sw_db, sw_changed, sw_changed_mask);
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (sw_changed !== 1'b0 || sw_changed_mask !== 10'h000 || sw_db !== 10'h000) begin
                failures++;
                $display("FAIL midrst held cyc=%0d db=%h changed=%b mask=%h required db=000 changed=0 mask=000",
                         c, sw_db, sw_changed, sw_changed_mask);
            end
        end
        rst    = 1'b0;
        cur_db = 10'h000;
        sb.push_back('{edge_no: 5, db: 10'h010, mask: 10'h010});
        for (int e = 0; e < 9; e++) begin
            sw_raw = 10'h010;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (sw_changed !== 1'b0 || sw_changed_mask !== 10'h000) begin
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL midrst unexpected pulse edge=%0d changed=%b mask=%h", e, sw_changed, sw_changed_mask);
                end else begin
                    ex = sb.pop_front();
                    if (e != ex.edge_no || sw_changed !== 1'b1 || sw_db !== ex.db || sw_changed_mask !== ex.mask) begin
                        failures++;
                        $display("FAIL midrst pulse edge=%0d db=%h mask=%h changed=%b required edge=%0d db=%h mask=%h changed=1",
                                 e, sw_db, sw_changed_mask, sw_changed, ex.edge_no, ex.db, ex.mask);
                    end
                    cur_db = ex.db;
                end
            end else if (sw_db !== cur_db) begin
                failures++;
                $display("FAIL midrst db edge=%0d got=%h required=%h", e, sw_db, cur_db);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL midrst missed pulse got=none required=%0d pending", sb.size());
        end
    endtask

    task automatic test_release();
        do_reset();
        // Raise nine bits first, then drop to 0F0 starting at edge 8 of the same run.
        sb.push_back('{edge_no: 5,  db: 10'h1FF, mask: 10'h1FF});
        sb.push_back('{edge_no: 13, db: 10'h0F0, mask: 10'h10F});
        for (int e = 0; e < 17; e++) begin
            sw_raw = (e < 8) ? 10'h1FF : 10'h0F0;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (sw_changed !== 1'b0 || sw_changed_mask !== 10'h000) begin
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL release unexpected pulse edge=%0d changed=%b mask=%h", e, sw_changed, sw_changed_mask);
                end else begin
                    ex = sb.pop_front();
                    if (e != ex.edge_no || sw_changed !== 1'b1 || sw_db !== ex.db || sw_changed_mask !== ex.mask) begin
                        failures++;
                        $display("FAIL release pulse edge=%0d db=%h mask=%h changed=%b required edge=%0d db=%h mask=%h changed=1",
                                 e, sw_db, sw_changed_mask, sw_changed, ex.edge_no, ex.db, ex.mask);
                    end
                    cur_db = ex.db;
                end
            end else if (sw_db !== cur_db) begin
                failures++;
                $display("FAIL release db edge=%0d got=%h required=%h", e, sw_db, cur_db);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL release missed pulse got=none required=%0d pending", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_edge();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_release();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Upstream conditioning stage for the board slide switches. It synchronises the asynchronous `sw` inputs into `clk` and debounces each bit independently. It presents a clean, registered switch vector to the switch decoder, plus a one-cycle change strobe with a per-bit mask. The block sits directly between the switch pins and the decoder's `sw[9:0]` input.

## Interface
- `WIDTH`, 10: number of switch bits.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required before a bit is accepted (10 ms at 50 MHz). Legal range ≥ 1.
- `clk` input 1: system clock; all state on rising edge.
- `rst` input 1: reset, asynchronous, active-high; one clock domain only.
- `sw_raw` input WIDTH: raw switch pins, asynchronous to `clk`.
- `sw_db` output WIDTH: debounced switch vector; feeds the decoder `sw` input.
- `sw_changed` output 1: one-cycle pulse on any `sw_db` bit update.
- `sw_changed_mask` output WIDTH: one-cycle per-bit pulse, high for each bit updated that cycle.

## Operation
- Per bit `i`: a 2-flop synchroniser (`s1[i]` then `s2[i]`), then a stability counter `cnt[i]` of width `$clog2(DEBOUNCE_CYCLES+1)`.
- Each edge, when `s2[i] == sw_db[i]`: `cnt[i] <= 0`. No change.
- Each edge, when `s2[i] != sw_db[i]` and `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i] <= cnt[i]+1`.
- Each edge, when `s2[i] != sw_db[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`:
  - `sw_db[i] <= s2[i]`
  - `cnt[i] <= 0`
  - `sw_changed_mask[i] <= 1`
- Otherwise `sw_changed_mask[i] <= 0`.
- `sw_changed` is registered as the OR of the next-state mask bits, so it is coincident with the mask.
- Bounce: any return of `s2[i]` to `sw_db[i]` before the count completes clears `cnt[i]`. The qualification window restarts from zero and nothing is emitted.
- Bits are fully independent. Several bits may update on the same edge, giving one `sw_changed` pulse with several mask bits set.
- The counter never wraps. It saturates by construction at `DEBOUNCE_CYCLES-1` and then clears.
- Reset: all outputs and internal state go to 0. `sw_db`, `sw_changed` and `sw_changed_mask` read 0 while `rst` is high.
- After reset release, switches held at 1 are accepted through the normal qualification path. This produces exactly one `sw_changed` pulse, which is intended.
- Reset asserted mid-count discards all partial counts. No output pulse is produced from a pre-reset count.

## Timing
- Reference point: `sw_raw[i]` changes and stays stable, and edge 0 is the first edge that samples it into `s1`.
  - `s2` updates at edge 1.
  - `sw_db[i]`, `sw_changed` and `sw_changed_mask[i]` update at edge `DEBOUNCE_CYCLES+1`.
- Strobe width is exactly one cycle. The strobe drops at the next edge unless another bit qualifies on that edge.
- A glitch of up to `DEBOUNCE_CYCLES-1` cycles as seen at `s2` never reaches `sw_db`.
- `rst` assertion clears outputs immediately, without waiting for `clk`. Deassertion is used synchronously: the first count can start at the first edge after release.
- All outputs are registered. There is no combinational path from `sw_raw` to any output.

## Structure
- Shared board package `board_pkg` holds:
  - `SW_WIDTH = 10`
  - `CLK_HZ = 50_000_000`
  - `DEBOUNCE_MS = 10`
  - derived `DEBOUNCE_CYCLES_DEFAULT`
- The top-level uses these package constants as its parameter defaults.
- Sub-module `sw_debounce_bit` contains the synchroniser, counter and one output bit with its mask pulse. It is instantiated WIDTH times in a generate loop.
- `sw_debounce` itself holds the generate loop and the `sw_changed` OR register.

## Test plan
Bench runs with `WIDTH=10`, `DEBOUNCE_CYCLES=4`.
- **Reset:** `rst` high with `sw_raw=10'h3FF` → `sw_db=0`, `sw_changed=0`, mask 0 throughout reset.
- **Clean edge:** after release, step `sw_raw` from `0` to `10'h001` before edge 0 → `sw_db=10'h001` at edge 5. `sw_changed=1` and mask `10'h001` for exactly one cycle, then 0.
- **Bounce:** toggle `sw_raw[3]` 1,0,1,0 with 3-cycle runs, then hold 1 → no output change during bouncing. `sw_db[3]=1` exactly 5 edges after the final rise is first sampled.
- **Simultaneous bits:** step `sw_raw` from `10'h000` to `10'h300` → `sw_db=10'h300` at edge 5, a single `sw_changed` pulse, mask `10'h300`.
- **Reset mid-count:** assert `rst` at edge 3 of a pending `10'h010` change, release 2 cycles later with input still `10'h010` → no pulse before release. `sw_db=10'h010` 5 edges after release.
- **Release:** from `sw_db=10'h1FF`, drop `sw_raw` to `10'h0F0` → `sw_db=10'h0F0` at edge 5, mask `10'h10F`.
